// File: rtl/jtag_seq_pkg.sv
// Shared types for the JTAG scan sequencer: controller state encoding and
// the default length of the Test-Logic-Reset walk.
package jtag_seq_pkg;

  localparam int TLR_CYCLES_DEF = 5;

  typedef enum logic [2:0] {
    ST_TLR_WALK,
    ST_RTI,
    ST_SEL_DR,
    ST_SEL_IR,
    ST_CAPTURE,
    ST_SHIFT,
    ST_EXIT1,
    ST_UPDATE
  } tap_state_t;

endpackage

// File: rtl/jtag_tdo_capture.sv
// TDO capture shift register. Bits enter at the MSB and move right, so after
// N shifts the first bit sits at BSC_SIZE-N; the UPDATE right-align moves it
// to bit 0 and zero-fills everything above the scan length.
module jtag_tdo_capture #(
  parameter int BSC_SIZE = 14,
  parameter int LEN_W    = $clog2(BSC_SIZE + 1)
) (
  input  logic                TCK,
  input  logic                reset,
  input  logic                shift_en,
  input  logic                update,
  input  logic                tdo,
  input  logic [LEN_W-1:0]    len,
  output logic [BSC_SIZE-1:0] captured
);

  logic [BSC_SIZE-1:0] shift_reg;
  logic [LEN_W-1:0]    align;

  assign align = LEN_W'(BSC_SIZE) - len;

  // Shift TDO in during SHIFT; publish the right-aligned result on UPDATE.
  always_ff @(posedge TCK) begin
    if (reset) begin
      shift_reg <= '0;
      captured  <= '0;
    end else begin
      if (shift_en) begin
        shift_reg <= {tdo, shift_reg[BSC_SIZE-1:1]};
      end
      if (update) begin
        captured <= shift_reg >> align;
      end
    end
  end

endmodule

// File: rtl/jtag_scan_sequencer.sv
// JTAG scan sequencer: walks the target TAP through IR/DR scans and TLR walks,
// mirroring the TAP state edge-for-edge and collecting TDO.
//
// state       | meaning
// ------------+---------------------------------------------------------
// TLR_WALK    | TMS high for TLR_CYCLES, then one TMS-low cycle into RTI
// RTI         | idle; accepts start / trst_req
// SEL_DR      | Select-DR-Scan; TMS picks IR (1) or DR (0) branch
// SEL_IR      | Select-IR-Scan
// CAPTURE     | Capture-xR; bit counter cleared
// SHIFT       | Shift-xR for exactly scan_len_q cycles, TMS on last bit
// EXIT1       | Exit1-xR
// UPDATE      | Update-xR; done pulse, captured bits published
module jtag_scan_sequencer
  import jtag_seq_pkg::*;
#(
  parameter int BSC_SIZE   = 14,
  parameter int LEN_W      = $clog2(BSC_SIZE + 1),
  parameter int TLR_CYCLES = TLR_CYCLES_DEF
) (
  input  logic                TCK,
  input  logic                reset,
  input  logic                start,
  input  logic                is_ir,
  input  logic [LEN_W-1:0]    scan_len,
  input  logic                trst_req,
  input  logic                TDO,
  output logic                TMS,
  output logic                load,
  output logic                enable_shift,
  output logic [BSC_SIZE-1:0] captured,
  output logic                busy,
  output logic                done,
  output logic                cmd_err
);

  localparam int TLR_W = $clog2(TLR_CYCLES + 1);

  tap_state_t          state;
  logic [TLR_W-1:0]    tlr_cnt;
  logic [LEN_W-1:0]    bit_cnt;
  logic [LEN_W-1:0]    len_q;
  logic                is_ir_q;
  logic                len_ok;
  logic                accept;
  logic                reject;
  logic                last_bit;
  logic                tlr_high;
  logic                tms_c;
  logic [BSC_SIZE-1:0] captured_q;

  assign len_ok   = (scan_len != '0) && (scan_len <= LEN_W'(BSC_SIZE));
  assign accept   = (state == ST_RTI) && start && !trst_req && len_ok;
  assign reject   = (state == ST_RTI) && start && !trst_req && !len_ok;
  assign last_bit = (bit_cnt == (len_q - LEN_W'(1)));
  assign tlr_high = (tlr_cnt < TLR_W'(TLR_CYCLES));

  // TAP-tracking state machine with its walk and bit counters.
  always_ff @(posedge TCK) begin
    if (reset) begin
      state   <= ST_TLR_WALK;
      tlr_cnt <= '0;
      bit_cnt <= '0;
      len_q   <= '0;
      is_ir_q <= 1'b0;
    end else begin
      case (state)
        ST_TLR_WALK: begin
          if (tlr_high) begin
            tlr_cnt <= tlr_cnt + TLR_W'(1);
          end else begin
            tlr_cnt <= '0;
            state   <= ST_RTI;
          end
        end
        ST_RTI: begin
          if (trst_req) begin
            tlr_cnt <= '0;
            state   <= ST_TLR_WALK;
          end else if (accept) begin
            is_ir_q <= is_ir;
            len_q   <= scan_len;
            state   <= ST_SEL_DR;
          end
        end
        ST_SEL_DR:  state <= is_ir_q ? ST_SEL_IR : ST_CAPTURE;
        ST_SEL_IR:  state <= ST_CAPTURE;
        ST_CAPTURE: begin
          bit_cnt <= '0;
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          bit_cnt <= bit_cnt + LEN_W'(1);
          if (last_bit) begin
            state <= ST_EXIT1;
          end
        end
        ST_EXIT1:   state <= ST_UPDATE;
        ST_UPDATE:  state <= ST_RTI;
        default:    state <= ST_TLR_WALK;
      endcase
    end
  end

  // TMS decode from state, latched command and (in RTI) the live request.
  always_comb begin
    tms_c = 1'b0;
    case (state)
      ST_TLR_WALK: tms_c = tlr_high;
      ST_RTI:      tms_c = accept;
      ST_SEL_DR:   tms_c = is_ir_q;
      ST_SHIFT:    tms_c = last_bit;
      ST_EXIT1:    tms_c = 1'b1;
      default:     tms_c = 1'b0;
    endcase
  end

  // Outputs are forced to their reset values for the whole reset assertion,
  // including the first cycle before the registers have been cleared.
  assign TMS          = reset | tms_c;
  assign load         = !reset && accept;
  assign cmd_err      = !reset && reject;
  assign enable_shift = !reset && (state == ST_SHIFT);
  assign done         = !reset && (state == ST_UPDATE);
  assign busy         = reset || (state != ST_RTI);
  assign captured     = reset ? '0 : captured_q;

  jtag_tdo_capture #(
    .BSC_SIZE (BSC_SIZE),
    .LEN_W    (LEN_W)
  ) u_capture (
    .TCK      (TCK),
    .reset    (reset),
    .shift_en (state == ST_SHIFT),
    .update   (state == ST_UPDATE),
    .tdo      (TDO),
    .len      (len_q),
    .captured (captured_q)
  );

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Directed bench for jtag_scan_sequencer: inputs change on the falling edge,
// outputs are checked 1 ns later, well away from the rising edge.
module tb_jtag_scan_sequencer;

  logic        TCK = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_ir = 1'b0;
  logic [3:0]  scan_len = 4'd0;
  logic        trst_req = 1'b0;
  logic        TDO = 1'b0;
  logic        TMS;
  logic        load;
  logic        enable_shift;
  logic [13:0] captured;
  logic        busy;
  logic        done;
  logic        cmd_err;

  int          checks = 0;
  int          errors = 0;
  logic [13:0] last_cap = '0;

  jtag_scan_sequencer dut (
    .TCK          (TCK),
    .reset        (reset),
    .start        (start),
    .is_ir        (is_ir),
    .scan_len     (scan_len),
    .trst_req     (trst_req),
    .TDO          (TDO),
    .TMS          (TMS),
    .load         (load),
    .enable_shift (enable_shift),
    .captured     (captured),
    .busy         (busy),
    .done         (done),
    .cmd_err      (cmd_err)
  );

  always #5 TCK = ~TCK;

  task automatic clear_inputs();
    start = 1'b0; trst_req = 1'b0; is_ir = 1'b0; scan_len = 4'd0; TDO = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge TCK);
    reset = 1'b1;
    clear_inputs();
    #1;
    for (int r = 0; r < 2; r++) begin
      checks++;
      if (TMS !== 1'b1 || busy !== 1'b1 || load !== 1'b0 || enable_shift !== 1'b0 ||
          done !== 1'b0 || cmd_err !== 1'b0 || captured !== 14'd0) begin
        errors++;
        $display("FAIL reset_outputs r=%0d got tms=%b busy=%b load=%b en=%b done=%b err=%b cap=%h want 1 1 0 0 0 0 0000",
                 r, TMS, busy, load, enable_shift, done, cmd_err, captured);
      end
      @(negedge TCK);
      #1;
    end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge TCK);
      reset = 1'b0;
      #1;
      checks++;
      if (TMS !== (i < 5) || busy !== 1'b1) begin
        errors++;
        $display("FAIL tlr_walk i=%0d got tms=%b busy=%b want tms=%b busy=1", i, TMS, busy, (i < 5));
      end
    end
    @(negedge TCK);
    #1;
    checks++;
    if (busy !== 1'b0 || TMS !== 1'b0) begin
      errors++;
      $display("FAIL reset_rti got busy=%b tms=%b want 0 0", busy, TMS);
    end
  endtask

  // One full scan starting in RTI; ends at the UPDATE cycle so a following
  // call starts in the very next (RTI) cycle.
  task automatic run_scan(input bit ir, input int len, input logic [13:0] pat,
                          input logic [13:0] exp_cap, input bit noise);
    int off;
    int last_k;
    bit in_shift;
    logic exp_tms;
    off    = ir ? 1 : 0;
    last_k = len + 4 + off;
    @(negedge TCK);
    start = 1'b1; trst_req = 1'b0; is_ir = ir; scan_len = 4'(len); TDO = 1'b0;
    #1;
    checks++;
    if (load !== 1'b1 || TMS !== 1'b1 || busy !== 1'b0 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL scan_start len=%0d got load=%b tms=%b busy=%b err=%b want 1 1 0 0",
               len, load, TMS, busy, cmd_err);
    end
    checks++;
    if (captured !== last_cap) begin
      errors++;
      $display("FAIL captured_hold got %h want %h", captured, last_cap);
    end
    for (int k = 1; k <= last_k; k++) begin
      @(negedge TCK);
      if (noise) begin
        start = 1'b1; trst_req = 1'b1; scan_len = 4'd0; is_ir = !ir;
      end else begin
        start = 1'b0; trst_req = 1'b0; scan_len = 4'd0;
      end
      in_shift = (k >= 3 + off) && (k <= len + 2 + off);
      TDO = in_shift ? pat[k - 3 - off] : 1'b0;
      if (k == 1) exp_tms = ir;
      else if (k == len + 2 + off || k == len + 3 + off) exp_tms = 1'b1;
      else exp_tms = 1'b0;
      #1;
      checks++;
      if (TMS !== exp_tms || enable_shift !== in_shift || done !== (k == last_k) ||
          busy !== 1'b1 || load !== 1'b0 || cmd_err !== 1'b0) begin
        errors++;
        $display("FAIL scan_cycle ir=%0d len=%0d k=%0d got tms=%b en=%b done=%b busy=%b load=%b err=%b want tms=%b en=%b done=%b busy=1 load=0 err=0",
                 ir, len, k, TMS, enable_shift, done, busy, load, cmd_err,
                 exp_tms, in_shift, (k == last_k));
      end
    end
    last_cap = exp_cap;
  endtask

  task automatic check_rti_captured(input logic [13:0] exp_cap);
    @(negedge TCK);
    clear_inputs();
    #1;
    checks++;
    if (captured !== exp_cap || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rti_captured got cap=%h busy=%b done=%b want cap=%h busy=0 done=0",
               captured, busy, done, exp_cap);
    end
  endtask

  task automatic test_dr_scan();
    run_scan(1'b0, 14, 14'h2A5C, 14'h2A5C, 1'b0);
    check_rti_captured(14'h2A5C);
  endtask

  // start/trst_req/scan_len/is_ir are toggled throughout the busy cycles.
  task automatic test_ir_scan_with_noise();
    run_scan(1'b1, 4, 14'b00000000001101, 14'b00000000001101, 1'b1);
    check_rti_captured(14'b00000000001101);
  endtask

  task automatic test_back_to_back();
    run_scan(1'b0, 3, 14'b110, 14'b110, 1'b0);
    run_scan(1'b1, 2, 14'b01, 14'b01, 1'b0);
    run_scan(1'b0, 1, 14'b1, 14'b1, 1'b0);
    check_rti_captured(14'b1);
  endtask

  task automatic test_cmd_err();
    for (int t = 0; t < 2; t++) begin
      @(negedge TCK);
      clear_inputs();
      start = 1'b1;
      scan_len = (t == 0) ? 4'd0 : 4'd15;
      #1;
      checks++;
      if (cmd_err !== 1'b1 || load !== 1'b0 || TMS !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL cmd_err_pulse len=%0d got err=%b load=%b tms=%b busy=%b want 1 0 0 0",
                 scan_len, cmd_err, load, TMS, busy);
      end
      @(negedge TCK);
      clear_inputs();
      #1;
      checks++;
      if (cmd_err !== 1'b0 || busy !== 1'b0 || captured !== last_cap) begin
        errors++;
        $display("FAIL cmd_err_after t=%0d got err=%b busy=%b cap=%h want 0 0 %h",
                 t, cmd_err, busy, captured, last_cap);
      end
    end
  endtask

  task automatic test_trst_with_start();
    @(negedge TCK);
    clear_inputs();
    start = 1'b1; trst_req = 1'b1; scan_len = 4'd5;
    #1;
    checks++;
    if (load !== 1'b0 || cmd_err !== 1'b0 || TMS !== 1'b0) begin
      errors++;
      $display("FAIL trst_start got load=%b err=%b tms=%b want 0 0 0", load, cmd_err, TMS);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge TCK);
      clear_inputs();
      #1;
      checks++;
      if (TMS !== (i < 5) || busy !== 1'b1 || done !== 1'b0 || load !== 1'b0) begin
        errors++;
        $display("FAIL trst_walk i=%0d got tms=%b busy=%b done=%b load=%b want tms=%b busy=1 done=0 load=0",
                 i, TMS, busy, done, load, (i < 5));
      end
    end
    check_rti_captured(last_cap);
  endtask

  task automatic test_reset_mid_scan();
    @(negedge TCK);
    clear_inputs();
    start = 1'b1; scan_len = 4'd14;
    for (int k = 1; k <= 8; k++) begin
      @(negedge TCK);
      clear_inputs();
      TDO = k[0];
    end
    // cycle k=9 is the 7th SHIFT cycle
    for (int r = 0; r < 2; r++) begin
      @(negedge TCK);
      clear_inputs();
      reset = 1'b1;
      #1;
      checks++;
      if (TMS !== 1'b1 || busy !== 1'b1 || load !== 1'b0 || enable_shift !== 1'b0 ||
          done !== 1'b0 || cmd_err !== 1'b0 || captured !== 14'd0) begin
        errors++;
        $display("FAIL midscan_reset r=%0d got tms=%b busy=%b load=%b en=%b done=%b err=%b cap=%h want 1 1 0 0 0 0 0000",
                 r, TMS, busy, load, enable_shift, done, cmd_err, captured);
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge TCK);
      reset = 1'b0;
      #1;
      checks++;
      if (TMS !== (i < 5) || busy !== 1'b1 || done !== 1'b0 || enable_shift !== 1'b0) begin
        errors++;
        $display("FAIL midscan_walk i=%0d got tms=%b busy=%b done=%b en=%b want tms=%b busy=1 done=0 en=0",
                 i, TMS, busy, done, enable_shift, (i < 5));
      end
    end
    last_cap = 14'd0;
    check_rti_captured(14'd0);
  endtask

  initial begin
    test_reset();
    test_dr_scan();
    test_ir_scan_with_noise();
    test_back_to_back();
    test_cmd_err();
    test_trst_with_start();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_scan_sequencer.md
JTAG_SCAN_SEQUENCER -- requirements
Module: jtag_scan_sequencer

Interface
REQ-001 Parameter BSC_SIZE, default 14, maximum scan length in bits.
REQ-002 Parameter LEN_W, default $clog2(BSC_SIZE+1), width of scan_len.
REQ-003 Parameter TLR_CYCLES, default 5, TMS-high cycles in a Test-Logic-Reset walk.
REQ-004 TCK  in  1  sole clock; all state updates on posedge TCK.
REQ-005 reset  in  1  one clock, reset is synchronous and active-high.
REQ-006 start  in  1  scan command request; sampled only in RTI.
REQ-007 is_ir  in  1  1 = IR scan, 0 = DR scan; captured with start.
REQ-008 scan_len  in  LEN_W  bits to shift; legal range 1..BSC_SIZE.
REQ-009 trst_req  in  1  request a TLR walk; sampled only in RTI.
REQ-010 TDO  in  1  serial data returned from the device under test.
REQ-011 TMS  out  1  TAP mode select, combinational from state and latched command.
REQ-012 load  out  1  one-cycle pulse; loads the TDI pattern generator.
REQ-013 enable_shift  out  1  high in every SHIFT cycle; advances the TDI pattern generator.
REQ-014 captured  out  BSC_SIZE  TDO bits of the last scan, right-aligned, bit 0 = first bit shifted.
REQ-015 busy  out  1  high in every state other than RTI.
REQ-016 done  out  1  one-cycle pulse in the UPDATE cycle.
REQ-017 cmd_err  out  1  one-cycle pulse when start is rejected.

Function
REQ-018 States: TLR_WALK, RTI, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE; the controller state tracks the target TAP state edge-for-edge.
REQ-019 TLR_WALK: TMS=1 for TLR_CYCLES cycles (counter), then TMS=0 for one cycle, then RTI.
REQ-020 RTI, idle: TMS=0, load=0.
REQ-021 RTI, legal start: TMS=1, load=1 that cycle, latch is_ir and scan_len, next state SEL_DR.
REQ-022 SEL_DR: TMS=is_ir_q; next state SEL_IR if is_ir_q, else CAPTURE.
REQ-023 SEL_IR: TMS=0; next state CAPTURE.
REQ-024 CAPTURE: TMS=0; bit counter cleared; next state SHIFT.
REQ-025 SHIFT: enable_shift=1; TDO shifted into capture register MSB-first-in (shift right, TDO enters bit BSC_SIZE-1); counter increments.
REQ-026 SHIFT: TMS=1 exactly when counter == scan_len_q-1, then next state EXIT1; otherwise TMS=0 and stay in SHIFT. SHIFT lasts exactly scan_len_q cycles.
REQ-027 EXIT1: TMS=1; next state UPDATE.
REQ-028 UPDATE: TMS=0, done=1; captured <= capture register >> (BSC_SIZE - scan_len_q); next state RTI.
REQ-029 captured holds its value until the next UPDATE.
REQ-030 start with scan_len==0 or scan_len>BSC_SIZE: rejected, cmd_err=1, load=0, TMS=0, remain RTI.
REQ-031 trst_req in RTI: enter TLR_WALK; trst_req wins over a simultaneous start (no load, no cmd_err).
REQ-032 start and trst_req outside RTI: ignored, no side effects.
REQ-033 Back-to-back: a start in the cycle after UPDATE (in RTI) is accepted; minimum command period is scan_len+5 cycles for DR and scan_len+6 cycles for IR.

Reset
REQ-034 While reset=1: state=TLR_WALK with counter cleared, TMS=1, load=0, enable_shift=0, done=0, cmd_err=0, busy=1, captured=0, capture register=0.
REQ-035 Reset asserted mid-scan aborts the scan without done; the full TLR walk restarts after reset deasserts.

Structure
REQ-036 Package jtag_seq_pkg holds the state enum and the TLR_CYCLES default.
REQ-037 Sub-module jtag_tdo_capture (BSC_SIZE shift register with shift enable and right-align on UPDATE); all other logic is in jtag_scan_sequencer.

Verification
REQ-038 Reset released -> TMS=1 for 5 cycles, then 0 for 1 cycle, then busy=0 (RTI).
REQ-039 DR scan with scan_len=14 and TDO driven 14'h2A5C LSB-first -> load pulse, TMS sequence 1,0,0,0×13,1,1,0; enable_shift high 14 cycles; done pulse; captured=14'h2A5C.
REQ-040 IR scan with scan_len=4 and TDO bits 1,0,1,1 -> SEL_IR visited (TMS 1,1,0,0); captured=4'b1101 zero-extended.
REQ-041 start with scan_len=0, then with scan_len=15 -> cmd_err pulse each time; load=0; busy stays 0.
REQ-042 start and trst_req in the same cycle -> TLR walk; no load; no done.
REQ-043 reset asserted at the 7th SHIFT cycle of a 14-bit scan -> no done; outputs at their reset values; full TLR walk after release.
